// File: rtl/ps2_kbd_pkg.sv
// Shared definitions for the PS/2 set-2 digit entry path.
//   state_t   : prefix-tracking states of the scancode sequencer
//   SC_*      : scancode bytes with special meaning to the sequencer
package ps2_kbd_pkg;

  typedef enum logic [1:0] {
    S_MAKE    = 2'd0,
    S_BRK     = 2'd1,
    S_EXT     = 2'd2,
    S_EXT_BRK = 2'd3
  } state_t;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;
  localparam logic [7:0] SC_BKSP  = 8'h66;

endpackage

// File: rtl/scancode_digit_decode.sv
// Combinational decoder from a PS/2 set-2 make code to a decimal digit.
//   code     : scancode byte
//   digit    : decoded value 0..9 (0 when not a digit key)
//   is_digit : high when code is one of the top-row digit keys
module scancode_digit_decode (
  input  logic [7:0] code,
  output logic [3:0] digit,
  output logic       is_digit
);

  always_comb begin
    digit    = 4'd0;
    is_digit = 1'b1;
    case (code)
      8'h45:   digit = 4'd0;
      8'h16:   digit = 4'd1;
      8'h1E:   digit = 4'd2;
      8'h26:   digit = 4'd3;
      8'h25:   digit = 4'd4;
      8'h2E:   digit = 4'd5;
      8'h36:   digit = 4'd6;
      8'h3D:   digit = 4'd7;
      8'h3E:   digit = 4'd8;
      8'h46:   digit = 4'd9;
      default: is_digit = 1'b0;
    endcase
  end

endmodule

// File: rtl/ps2_digit_entry_ctrl.sv
// Turns a stream of PS/2 set-2 scancode bytes into committed multi-digit
// BCD entries. Make codes of digit keys are appended to an edit buffer,
// backspace removes the newest digit, Enter (main or keypad) commits the
// buffer to a valid/ready output register.
//   clk, areset     : clock, asynchronous active-high reset
//   byte_in/valid   : scancode byte and its one-cycle strobe
//   out_ready       : consumer accepts the committed entry this cycle
//   clear_err       : clears the sticky error flags
//   out_valid/bcd/ndigits : committed entry, right-justified BCD
//   entry_count     : digits currently held in the edit buffer
//   err_overflow    : sticky, a digit was typed into a full buffer
//   err_overrun     : sticky, a commit was dropped while output pending
module ps2_digit_entry_ctrl
  import ps2_kbd_pkg::*;
#(
  parameter  int MAX_DIGITS = 4,
  localparam int CW         = $clog2(MAX_DIGITS + 1),
  localparam int BW         = 4 * MAX_DIGITS
) (
  input  logic          clk,
  input  logic          areset,
  input  logic [7:0]    byte_in,
  input  logic          byte_valid,
  input  logic          out_ready,
  input  logic          clear_err,
  output logic          out_valid,
  output logic [BW-1:0] out_bcd,
  output logic [CW-1:0] out_ndigits,
  output logic [CW-1:0] entry_count,
  output logic          err_overflow,
  output logic          err_overrun
);

  state_t        state_q, state_d;
  logic [BW-1:0] buf_q, buf_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [BW-1:0] out_bcd_q, out_bcd_d;
  logic [CW-1:0] out_nd_q, out_nd_d;
  logic          err_ovf_q, err_ovf_d;
  logic          err_ovr_q, err_ovr_d;

  logic [3:0]    dec_digit;
  logic          dec_is_digit;

  scancode_digit_decode u_decode (
    .code     (byte_in),
    .digit    (dec_digit),
    .is_digit (dec_is_digit)
  );

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q     <= S_MAKE;
      buf_q       <= '0;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_bcd_q   <= '0;
      out_nd_q    <= '0;
      err_ovf_q   <= 1'b0;
      err_ovr_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      buf_q       <= buf_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_bcd_q   <= out_bcd_d;
      out_nd_q    <= out_nd_d;
      err_ovf_q   <= err_ovf_d;
      err_ovr_q   <= err_ovr_d;
    end
  end

  always_comb begin
    logic commit;
    logic ovf_set;
    logic ovr_set;

    state_d     = state_q;
    buf_d       = buf_q;
    cnt_d       = cnt_q;
    out_valid_d = out_valid_q;
    out_bcd_d   = out_bcd_q;
    out_nd_d    = out_nd_q;
    commit      = 1'b0;
    ovf_set     = 1'b0;
    ovr_set     = 1'b0;

    if (byte_valid) begin
      case (state_q)
        S_MAKE: begin
          if (byte_in == SC_BREAK) begin
            state_d = S_BRK;
          end else if (byte_in == SC_EXT) begin
            state_d = S_EXT;
          end else if (dec_is_digit) begin
            if (cnt_q < CW'(MAX_DIGITS)) begin
              buf_d = (buf_q << 4) | BW'(dec_digit);
              cnt_d = cnt_q + CW'(1);
            end else begin
              ovf_set = 1'b1;
            end
          end else if (byte_in == SC_BKSP) begin
            if (cnt_q != '0) begin
              buf_d = buf_q >> 4;
              cnt_d = cnt_q - CW'(1);
            end
          end else if (byte_in == SC_ENTER) begin
            commit = 1'b1;
          end
        end
        // Release codes are swallowed whole so a digit's break never edits.
        S_BRK: state_d = S_MAKE;
        S_EXT: begin
          if (byte_in == SC_BREAK) begin
            state_d = S_EXT_BRK;
          end else begin
            commit  = (byte_in == SC_ENTER);
            state_d = S_MAKE;
          end
        end
        S_EXT_BRK: state_d = S_MAKE;
        default:   state_d = S_MAKE;
      endcase
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A commit may reload in the same cycle the old entry is accepted.
    if (commit && (cnt_q != '0)) begin
      if (!out_valid_q || out_ready) begin
        out_bcd_d   = buf_q;
        out_nd_d    = cnt_q;
        out_valid_d = 1'b1;
      end else begin
        ovr_set = 1'b1;
      end
      buf_d = '0;
      cnt_d = '0;
    end

    // Set wins over a simultaneous clear.
    err_ovf_d = (err_ovf_q && !clear_err) || ovf_set;
    err_ovr_d = (err_ovr_q && !clear_err) || ovr_set;
  end

  assign out_valid    = out_valid_q;
  assign out_bcd      = out_bcd_q;
  assign out_ndigits  = out_nd_q;
  assign entry_count  = cnt_q;
  assign err_overflow = err_ovf_q;
  assign err_overrun  = err_ovr_q;

endmodule

// File: tb/tb_ps2_digit_entry_ctrl.sv
module tb_ps2_digit_entry_ctrl;

  localparam int MAXD = 4;
  localparam int CW   = 3;

  logic             clk = 1'b0;
  logic             areset;
  logic [7:0]       byte_in;
  logic             byte_valid;
  logic             out_ready;
  logic             clear_err;
  logic             out_valid;
  logic [4*MAXD-1:0] out_bcd;
  logic [CW-1:0]    out_ndigits;
  logic [CW-1:0]    entry_count;
  logic             err_overflow;
  logic             err_overrun;

  always #5 clk = ~clk;

  ps2_digit_entry_ctrl #(.MAX_DIGITS(MAXD)) dut (
    .clk          (clk),
    .areset       (areset),
    .byte_in      (byte_in),
    .byte_valid   (byte_valid),
    .out_ready    (out_ready),
    .clear_err    (clear_err),
    .out_valid    (out_valid),
    .out_bcd      (out_bcd),
    .out_ndigits  (out_ndigits),
    .entry_count  (entry_count),
    .err_overflow (err_overflow),
    .err_overrun  (err_overrun)
  );

  typedef struct {
    logic [15:0] bcd;
    int          nd;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   mdig[$];
  int   mst      = 0;
  bit   m_ovf    = 0;
  bit   m_ovr    = 0;
  bit   mon_en   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int dec_digit(input logic [7:0] b);
    logic [7:0] codes [10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25,
                               8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    for (int i = 0; i < 10; i++) if (codes[i] == b) return i;
    return -1;
  endfunction

  function automatic logic [15:0] pack_digits();
    logic [15:0] v = 16'h0;
    foreach (mdig[i]) v = (v << 4) | 16'(mdig[i]);
    return v;
  endfunction

  // Reference behaviour applied once per accepted byte.
  task automatic model_byte(input logic [7:0] b);
    bit   commit = 0;
    int   d      = dec_digit(b);
    exp_t e;
    case (mst)
      0: begin
        if (b == 8'hF0) mst = 1;
        else if (b == 8'hE0) mst = 2;
        else if (d >= 0) begin
          if (mdig.size() < MAXD) mdig.push_back(d);
          else m_ovf = 1;
        end else if (b == 8'h66) begin
          if (mdig.size() > 0) void'(mdig.pop_back());
        end else if (b == 8'h5A) commit = 1;
      end
      2: begin
        if (b == 8'hF0) mst = 3;
        else begin
          commit = (b == 8'h5A);
          mst = 0;
        end
      end
      default: mst = 0;
    endcase
    if (commit && mdig.size() > 0) begin
      // Any entry accepted this cycle has already been popped by the monitor.
      if (exp_q.size() == 0) begin
        e.bcd = pack_digits();
        e.nd  = mdig.size();
        exp_q.push_back(e);
      end else begin
        m_ovr = 1;
      end
      mdig.delete();
    end
  endtask

  task automatic send(input logic [7:0] b, input logic rdy);
    @(posedge clk);
    #1;
    byte_in    = b;
    byte_valid = 1'b1;
    out_ready  = rdy;
    @(negedge clk);
    #1;
    model_byte(b);
    @(posedge clk);
    #1;
    byte_valid = 1'b0;
    byte_in    = 8'($urandom);
  endtask

  task automatic do_clear();
    @(posedge clk);
    #1 clear_err = 1'b1;
    @(negedge clk);
    #1;
    m_ovf = 0;
    m_ovr = 0;
    @(posedge clk);
    #1 clear_err = 1'b0;
  endtask

  task automatic idle(input int n, input logic rdy);
    @(posedge clk);
    #1 out_ready = rdy;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    #1;
    areset = 1'b1;
    mdig.delete();
    exp_q.delete();
    mst   = 0;
    m_ovf = 0;
    m_ovr = 0;
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bcd", out_bcd, 0);
    check("rst_out_ndigits", out_ndigits, 0);
    check("rst_entry_count", entry_count, 0);
    check("rst_err_overflow", err_overflow, 0);
    check("rst_err_overrun", err_overrun, 0);
    repeat (2) @(negedge clk);
    #1 areset = 1'b0;
  endtask

  always @(negedge clk) begin
    if (mon_en && !areset) begin
      check("entry_count", entry_count, mdig.size());
      check("err_overflow", err_overflow, m_ovf);
      check("err_overrun", err_overrun, m_ovr);
      check("out_valid", out_valid, exp_q.size() > 0);
      if (out_valid && exp_q.size() > 0) begin
        check("out_bcd", out_bcd, exp_q[0].bcd);
        check("out_ndigits", out_ndigits, exp_q[0].nd);
        if (out_ready) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    logic [7:0] pool [14] = '{8'h16, 8'h1E, 8'h26, 8'h45, 8'h46, 8'h3D,
                              8'hF0, 8'hE0, 8'h5A, 8'h5A, 8'h66, 8'h66,
                              8'h12, 8'h29};
    areset     = 1'b0;
    byte_in    = 8'h00;
    byte_valid = 1'b0;
    out_ready  = 1'b0;
    clear_err  = 1'b0;
    #2;
    do_reset();
    mon_en = 1;

    // "12" with releases, held then the trailing Enter release is inert
    foreach (pool[i]) ;
    send(8'h16, 0); send(8'hF0, 0); send(8'h16, 0);
    send(8'h1E, 0); send(8'hF0, 0); send(8'h1E, 0);
    send(8'h5A, 0);
    send(8'hF0, 0); send(8'h5A, 0);
    idle(3, 0);
    idle(3, 1);

    // "39" via backspace, consumer ready
    send(8'h26, 1); send(8'h25, 1); send(8'h66, 1);
    send(8'h46, 1); send(8'h5A, 1);
    idle(3, 1);

    // overflow on fifth digit, then clear
    send(8'h16, 1); send(8'h1E, 1); send(8'h26, 1);
    send(8'h25, 1); send(8'h2E, 1); send(8'h5A, 1);
    idle(2, 1);
    do_clear();
    idle(2, 1);

    // extended prefixes never edit; empty keypad Enter commits nothing
    send(8'hE0, 1); send(8'h45, 1);
    send(8'hE0, 1); send(8'hF0, 1); send(8'h45, 1);
    send(8'hE0, 1); send(8'h5A, 1);
    idle(2, 1);
    send(8'h45, 1); send(8'hE0, 1); send(8'h5A, 1);
    idle(2, 1);

    // overrun while consumer stalls
    send(8'h3D, 0); send(8'h5A, 0);
    send(8'h3E, 0); send(8'h5A, 0);
    idle(3, 0);
    idle(2, 1);
    do_clear();

    // mid-sequence reset after a dangling break prefix
    send(8'h16, 1); send(8'h1E, 1); send(8'hF0, 1);
    do_reset();
    send(8'h26, 1);
    idle(1, 1);
    send(8'h5A, 1);
    idle(2, 1);

    // random stream with a randomly stalling consumer
    for (int i = 0; i < 300; i++) begin
      send(pool[$urandom_range(13, 0)], 1'($urandom_range(1, 0)));
      if (i % 50 == 49) do_clear();
    end
    idle(4, 1);
    check("scoreboard_drained", exp_q.size(), 0);

    mon_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
